// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a little-endian byte stream into words
// and writes them at consecutive addresses. Optional checksum trailer: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int          SIZE      = 2048,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] length,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic        csum_err,
`endif
    output logic        overflow
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // RECV  | accepting bytes of the current word (or the checksum trailer)
    // WRITE | one-cycle write strobe for the assembled word
    // DONE  | load finished, start re-arms
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t      state;
    logic [15:0] remaining;
    logic [31:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [23:0] asm_word;
    logic [31:0] full_word;
    logic        byte_fire;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum;
    logic        csum_phase;
`endif

    assign full_word = {in_data, asm_word};
    assign byte_fire = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_a     <= BASE_ADDR;
            mem_wd    <= 32'h0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            remaining <= 16'h0;
            word_cnt  <= 32'h0;
            byte_idx  <= 2'd0;
            asm_word  <= 24'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= 32'h0;
            csum_phase <= 1'b0;
            csum_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        remaining <= length;
                        done      <= 1'b0;
                        overflow  <= 1'b0;
                        mem_a     <= BASE_ADDR;
                        byte_idx  <= 2'd0;
                        word_cnt  <= 32'h0;
                        asm_word  <= 24'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum        <= 32'h0;
                        csum_phase <= 1'b0;
                        csum_err   <= 1'b0;
`endif
                        if (length == 16'h0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= RECV;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                end

                RECV: begin
                    if (byte_fire) begin
                        case (byte_idx)
                            2'd0:    asm_word[7:0]   <= in_data;
                            2'd1:    asm_word[15:8]  <= in_data;
                            2'd2:    asm_word[23:16] <= in_data;
                            default: asm_word        <= asm_word;
                        endcase
                        if (byte_idx == 2'd3) begin
                            byte_idx <= 2'd0;
                            in_ready <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            if (csum_phase) begin
                                // Trailer word is compared, never written.
                                state      <= DONE;
                                csum_phase <= 1'b0;
                                csum_err   <= (sum != full_word);
                                done       <= 1'b1;
                                busy       <= 1'b0;
                                cpu_hold   <= 1'b0;
                            end else begin
                                state  <= WRITE;
                                mem_wd <= full_word;
                                mem_we <= 1'b1;
                            end
`else
                            state  <= WRITE;
                            mem_wd <= full_word;
                            mem_we <= 1'b1;
`endif
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end

                WRITE: begin
                    mem_we    <= 1'b0;
                    mem_a     <= mem_a + 32'd4;
                    remaining <= remaining - 16'd1;
                    word_cnt  <= word_cnt + 32'd1;
                    byte_idx  <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum <= sum + mem_wd;
`endif
                    if (remaining == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state      <= RECV;
                        csum_phase <= 1'b1;
                        in_ready   <= 1'b1;
`else
                        state    <= DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
`endif
                    end else if (word_cnt + 32'd1 == 32'(SIZE)) begin
                        // Memory full: truncate rather than wrap past the last word.
                        state    <= DONE;
                        overflow <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else begin
                        state    <= RECV;
                        in_ready <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
